// File: rtl/serial_ripple_subtractor_53bit.sv
// Digit-serial unsigned subtractor: computes A - B one DIGIT-wide slice per
// cycle and carries the borrow between slices in a register. The result is
// {borrow_out, difference}, which is the same layout the ripple adder uses.

// One-bit full subtractor cell: d = a - b - bin, bout set when that underflows.
module serial_ripple_subtractor_53bit_fs (
    input  logic a,
    input  logic b,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = a ^ b ^ bin;
    assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

module serial_ripple_subtractor_53bit #(
    parameter int WIDTH = 53,
    parameter int DIGIT = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [WIDTH-1:0] i_minuend,
    input  logic [WIDTH-1:0] i_subtrahend,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [WIDTH:0]   o_result,
    output logic             o_busy
);
    localparam int NDIG = (WIDTH + DIGIT - 1) / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [WIDTH-1:0]  a_q, b_q, res_q, res_nxt;
    logic              res_msb_q;
    logic              borrow_q;
    logic [CW-1:0]     cnt_q;
    logic              last_dig;
    logic              accept;

    // Operand slices, one per digit; bits past WIDTH-1 in the top slice are
    // tied to zero so the borrow out of that slice equals the borrow at bit
    // WIDTH-1 (a=b=0 cells just pass their borrow through).
    logic [DIGIT-1:0]  a_digs [NDIG];
    logic [DIGIT-1:0]  b_digs [NDIG];
    logic [DIGIT-1:0]  a_dig, b_dig, d_dig;
    logic [DIGIT:0]    bchain;

    genvar gk, gj, gi;
    generate
        for (gk = 0; gk < NDIG; gk++) begin : g_dig
            for (gj = 0; gj < DIGIT; gj++) begin : g_bit
                if (gk * DIGIT + gj < WIDTH) begin : g_live
                    assign a_digs[gk][gj] = a_q[gk*DIGIT+gj];
                    assign b_digs[gk][gj] = b_q[gk*DIGIT+gj];
                end else begin : g_pad
                    assign a_digs[gk][gj] = 1'b0;
                    assign b_digs[gk][gj] = 1'b0;
                end
            end
        end
    endgenerate

    // Select the slice addressed by the digit counter.
    always_comb begin
        a_dig = '0;
        b_dig = '0;
        for (int k = 0; k < NDIG; k++) begin
            if (cnt_q == CW'(k)) begin
                a_dig = a_digs[k];
                b_dig = b_digs[k];
            end
        end
    end

    // Borrow ripples through DIGIT cells within one cycle.
    assign bchain[0] = borrow_q;

    serial_ripple_subtractor_53bit_fs u_fs [DIGIT-1:0] (
        .a    (a_dig),
        .b    (b_dig),
        .bin  (bchain[DIGIT-1:0]),
        .d    (d_dig),
        .bout (bchain[DIGIT:1])
    );

    // Only the bits of the current digit are replaced; bits past WIDTH-1
    // have no storage and are never written.
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_res
            assign res_nxt[gi] = (cnt_q == CW'(gi / DIGIT)) ? d_dig[gi % DIGIT] : res_q[gi];
        end
    endgenerate

    assign last_dig = (cnt_q == CW'(NDIG - 1));
    assign accept   = (state == S_IDLE) && i_valid;

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next-state logic and handshake outputs decoded from state.
    always_comb begin
        state_nxt = state;
        o_ready   = 1'b0;
        o_valid   = 1'b0;
        o_busy    = 1'b0;
        case (state)
            S_IDLE: begin
                o_ready = 1'b1;
                if (i_valid) state_nxt = S_RUN;
            end
            S_RUN: begin
                o_busy = 1'b1;
                if (last_dig) state_nxt = S_DONE;
            end
            S_DONE: begin
                o_busy  = 1'b1;
                o_valid = 1'b1;
                if (i_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Operand capture, per-digit result write and borrow/counter update.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            res_msb_q <= 1'b0;
            borrow_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            if (accept) begin
                a_q      <= i_minuend;
                b_q      <= i_subtrahend;
                borrow_q <= 1'b0;
                cnt_q    <= '0;
            end else if (state == S_RUN) begin
                res_q    <= res_nxt;
                borrow_q <= bchain[DIGIT];
                if (last_dig) begin
                    res_msb_q <= bchain[DIGIT];
                    cnt_q     <= '0;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end

    assign o_result = {res_msb_q, res_q};

endmodule

// File: tb/tb_serial_ripple_subtractor_53bit.sv
// Directed and randomized checks of the digit-serial subtractor at DIGIT = 8, 1, 53.
module tb_serial_ripple_subtractor_53bit;
    localparam int W = 53;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         iv   [3];
    logic         ir   [3];
    logic [W-1:0] ia   [3];
    logic [W-1:0] ib   [3];
    logic         ordy [3];
    logic         ov   [3];
    logic         obsy [3];
    logic [W:0]   ores [3];
    int           nd_tab [3] = '{7, 53, 1};

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    serial_ripple_subtractor_53bit #(.WIDTH(W), .DIGIT(8)) u_d8 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[0]), .o_ready(ordy[0]),
        .i_minuend(ia[0]), .i_subtrahend(ib[0]), .o_valid(ov[0]), .i_ready(ir[0]),
        .o_result(ores[0]), .o_busy(obsy[0]));

    serial_ripple_subtractor_53bit #(.WIDTH(W), .DIGIT(1)) u_d1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[1]), .o_ready(ordy[1]),
        .i_minuend(ia[1]), .i_subtrahend(ib[1]), .o_valid(ov[1]), .i_ready(ir[1]),
        .o_result(ores[1]), .o_busy(obsy[1]));

    serial_ripple_subtractor_53bit #(.WIDTH(W), .DIGIT(53)) u_d53 (
        .i_clk(clk), .i_rst_n(rst_n), .i_valid(iv[2]), .o_ready(ordy[2]),
        .i_minuend(ia[2]), .i_subtrahend(ib[2]), .o_valid(ov[2]), .i_ready(ir[2]),
        .o_result(ores[2]), .o_busy(obsy[2]));

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // One transaction on instance idx; starts and ends 1 time unit after a rising edge.
    task automatic run_op(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [W:0] exp, input int gap_v, input int gap_r,
                          input string tag);
        int cyc;
        repeat (gap_v) begin
            @(posedge clk); #1;
        end
        chk({tag, ":rdy_idle"}, 64'(ordy[idx]), 64'd1);
        ia[idx] = a;
        ib[idx] = b;
        iv[idx] = 1'b1;
        ir[idx] = (gap_r == 0);
        @(posedge clk); #1;
        iv[idx] = 1'b0;
        ia[idx] = ~a;
        ib[idx] = ~b;
        cyc = 0;
        while (!ov[idx] && cyc < 200) begin
            chk({tag, ":busy_run"}, 64'(obsy[idx]), 64'd1);
            @(posedge clk); #1;
            cyc++;
        end
        chk({tag, ":latency"}, 64'(cyc), 64'(nd_tab[idx]));
        chk({tag, ":result"}, 64'(ores[idx]), 64'(exp));
        chk({tag, ":rdy_done"}, 64'(ordy[idx]), 64'd0);
        if (gap_r > 0) begin
            iv[idx] = 1'b1;
            repeat (gap_r) begin
                @(posedge clk); #1;
                chk({tag, ":bp_valid"}, 64'(ov[idx]), 64'd1);
                chk({tag, ":bp_result"}, 64'(ores[idx]), 64'(exp));
                chk({tag, ":bp_rdy"}, 64'(ordy[idx]), 64'd0);
            end
            iv[idx] = 1'b0;
            ir[idx] = 1'b1;
        end
        @(posedge clk); #1;
        chk({tag, ":valid_drop"}, 64'(ov[idx]), 64'd0);
        chk({tag, ":rdy_back"}, 64'(ordy[idx]), 64'd1);
        ir[idx] = 1'b0;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iv[i] = 1'b0;
            ir[i] = 1'b0;
            ia[i] = '0;
            ib[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            chk("rst_ready", 64'(ordy[i]), 64'd1);
            chk("rst_valid", 64'(ov[i]), 64'd0);
            chk("rst_busy", 64'(obsy[i]), 64'd0);
            chk("rst_result", 64'(ores[i]), 64'd0);
        end
        rst_n = 1'b1;

        // i_ready and operand changes in IDLE with no handshake do nothing.
        ir[0] = 1'b1;
        ia[0] = 53'd99;
        repeat (2) begin
            @(posedge clk); #1;
            chk("idle_noop_valid", 64'(ov[0]), 64'd0);
            chk("idle_noop_busy", 64'(obsy[0]), 64'd0);
        end
        ir[0] = 1'b0;

        run_op(0, 53'd5, 53'd3, 54'd2, 0, 1, "d5m3");
        run_op(0, 53'd0, 53'd1, 54'h3F_FFFF_FFFF_FFFF, 1, 1, "d0m1");
        run_op(0, 53'h100, 53'd1, 54'hFF, 0, 0, "d100m1");
        run_op(0, 53'h1F_FFFF_FFFF_FFFF, 53'h1F_FFFF_FFFF_FFFF, 54'd0, 2, 10, "dmaxeq");
        run_op(0, 53'd0, 53'd1, 54'h3F_FFFF_FFFF_FFFF, 0, 1, "d0m1b");

        // Abort during RUN, with digit 3 pending.
        ia[0] = 53'h7;
        ib[0] = 53'h1;
        iv[0] = 1'b1;
        @(posedge clk); #1;
        iv[0] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("abort_busy_before", 64'(obsy[0]), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("abort_ready", 64'(ordy[0]), 64'd1);
        chk("abort_valid", 64'(ov[0]), 64'd0);
        chk("abort_busy", 64'(obsy[0]), 64'd0);
        chk("abort_result", 64'(ores[0]), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        run_op(0, 53'd10, 53'd20, 54'h3F_FFFF_FFFF_FFF6, 1, 2, "d10m20");

        // DIGIT=1 and DIGIT=53 corner vectors.
        run_op(1, 53'd0, 53'd1, 54'h3F_FFFF_FFFF_FFFF, 0, 1, "g1_0m1");
        run_op(2, 53'd0, 53'd1, 54'h3F_FFFF_FFFF_FFFF, 0, 1, "g53_0m1");
        run_op(2, 53'h100, 53'd1, 54'hFF, 0, 0, "g53_100m1");

        // Randomized pairs against a plain arithmetic reference.
        for (int idx = 0; idx < 3; idx++) begin
            int n_ops;
            n_ops = (idx == 1) ? 300 : 1000;
            for (int n = 0; n < n_ops; n++) begin
                ra = W'({$urandom(), $urandom()});
                rb = W'({$urandom(), $urandom()});
                case ($urandom_range(0, 7))
                    0: rb = ra;
                    1: rb = ra + W'(1);
                    2: ra = '0;
                    default: ;
                endcase
                run_op(idx, ra, rb, {1'b0, ra} - {1'b0, rb},
                       $urandom_range(0, 2), $urandom_range(0, 2), "rand");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
